id_token_stat: RTL
==================

// Module: id_token_stat
// PURPOSE
//   Downstream consumer of id_fsm. Watches the same char stream plus id_fsm's
//   registered hit output. Delimits completed identifier tokens (letter+ digit+)
//   and measures their length in chars. Queues lengths in a small FIFO with a
//   valid/ready output and keeps a running token count.
// PARAMETERS
//   LW     6   width of tok_len; lengths saturate at 2^LW-1
//   CW     16  width of tok_cnt; saturates at 2^CW-1
//   DEPTH  4   FIFO entries, power of two, >=2
// PORTS
//   clk        in   1      clock, all state updates on posedge
//   reset      in   1      synchronous, active-high
//   char       in   8      ASCII char, same signal that drives id_fsm.char
//   id_hit     in   1      id_fsm.out (registered result for char sampled last edge)
//   tok_ready  in   1      consumer accepts head entry when tok_valid=1
//   tok_valid  out  1      FIFO non-empty
//   tok_len    out  LW     length of head token (letters+digits)
//   tok_cnt    out  CW     tokens completed since reset (incl. dropped)
//   ovf        out  1      sticky: a token was dropped on full FIFO
// BEHAVIOUR
// - Reset (sync, active-high): tok_valid=0, tok_len=0, tok_cnt=0, ovf=0,
//   FIFO empty, c_d=0, prev_hit=0, len=0, in_run=0. Reset overrides all.
// - Alignment: c_d <= char every edge. At edge t+1 the pair (c_d, id_hit) is
//   processed; both describe the char sampled at edge t.
// - Classes: L = A-Z/a-z, D = 0-9, X = anything else.
// - Run tracking per processed pair:
//     L: if (!in_run || prev_hit) len<=1 else len<=sat(len+1); in_run<=1
//     D: if (in_run) len<=sat(len+1); else len unchanged (0)
//     X: len<=0; in_run<=0
//   prev_hit <= id_hit every processed pair.
// - Token complete: prev_hit=1 && id_hit=0 && in_run=1. Token length = len
//   before this pair's update. Same pair may also start a new run (L case).
// - On completion: tok_cnt<=sat(tok_cnt+1); push len into FIFO if not full,
//   or if full and pop happens same edge (accepted); else drop, ovf<=1.
// - Pop: tok_valid && tok_ready at edge -> head advances. Pop on empty ignored.
// - tok_len driven from head entry; holds value while tok_valid && !tok_ready.
//   When empty tok_len=0.
// - Latency: terminating char sampled at edge t -> processed at edge t+1 ->
//   tok_valid=1 after edge t+1 (FIFO was empty).
// - Pointers wrap mod DEPTH; occupancy counter 0..DEPTH distinguishes full/empty.
// - Reset mid-run: run context lost; id_hit=1 seen with in_run=0 never
//   completes a token (no push, no count).
// - ovf clears only on reset.
// TESTING
// 1 Reset, stream "ab12 " then 'x' filler, tok_ready=1 -> one token,
//   tok_len=4, tok_valid high 1 cycle, 1 cycle after ' ' processed; tok_cnt=1.
// 2 Stream "a1b22;" -> two tokens: lengths 2 then 3 (b restart via prev_hit);
//   tok_cnt=2.
// 3 Stream "abc ", "9x ", "12 " -> no token (no trailing digit / no letter);
//   tok_valid=0, tok_cnt=0.
// 4 tok_ready=0, five tokens "a1 " x5 -> FIFO holds 4 (len=2 each), 5th
//   dropped, ovf=1, tok_cnt=5; raise tok_ready -> 4 pops then tok_valid=0.
// 5 FIFO full, tok_ready=1 on the edge a 5th token completes -> accepted,
//   ovf stays 0, occupancy remains 4.
// 6 LW=3, "abcdefgh12 " -> tok_len=7 (saturated); assert reset mid "ab1" ->
//   all outputs 0 next cycle, trailing "2 " yields no token.

Source files
------------

// File: rtl/id_token_stat.sv
// Identifier token statistics: delimits letter+digit+ tokens using id_fsm's hit output,
// queues their lengths in a small FIFO and keeps a saturating token count.
module id_token_stat #(
    parameter int LW    = 6,
    parameter int CW    = 16,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    char,
    input  logic          id_hit,
    input  logic          tok_ready,
    output logic          tok_valid,
    output logic [LW-1:0] tok_len,
    output logic [CW-1:0] tok_cnt,
    output logic          ovf
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] OCC_FULL = (AW + 1)'(DEPTH);
    localparam logic [LW-1:0] LEN_MAX = '1;
    localparam logic [CW-1:0] CNT_MAX = '1;

    // Run tracking state
    logic [7:0]    c_d;
    logic          prev_hit;
    logic          in_run;
    logic [LW-1:0] len;

    logic          is_letter;
    logic          is_digit;
    logic [LW-1:0] len_inc;
    logic [LW-1:0] len_nxt;
    logic          in_run_nxt;
    logic          tok_done;

    // FIFO state
    logic [LW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;

    logic full;
    logic push;
    logic pop;
    logic drop;

    // c_d and id_hit both describe the char sampled on the previous edge.
    always_comb begin
        is_letter = ((c_d >= 8'h41) && (c_d <= 8'h5a)) ||
                    ((c_d >= 8'h61) && (c_d <= 8'h7a));
        is_digit  = (c_d >= 8'h30) && (c_d <= 8'h39);
    end

    always_comb begin
        len_inc    = (len == LEN_MAX) ? len : len + 1'b1;
        len_nxt    = len;
        in_run_nxt = in_run;
        if (is_letter) begin
            // A letter right after a hit begins a fresh identifier.
            len_nxt    = (!in_run || prev_hit) ? LW'(1) : len_inc;
            in_run_nxt = 1'b1;
        end else if (is_digit) begin
            if (in_run) begin
                len_nxt = len_inc;
            end
        end else begin
            len_nxt    = '0;
            in_run_nxt = 1'b0;
        end
    end

    // Completion uses len before this pair's update.
    assign tok_done = prev_hit && !id_hit && in_run;

    always_ff @(posedge clk) begin
        if (reset) begin
            c_d      <= '0;
            prev_hit <= 1'b0;
            len      <= '0;
            in_run   <= 1'b0;
        end else begin
            c_d      <= char;
            prev_hit <= id_hit;
            len      <= len_nxt;
            in_run   <= in_run_nxt;
        end
    end

    // Output handshake: the head entry transfers on any edge where
    // tok_valid && tok_ready; tok_len is stable while tok_valid && !tok_ready.
    assign tok_valid = (occ != '0);
    assign full      = (occ == OCC_FULL);
    assign pop       = tok_valid && tok_ready;
    assign push      = tok_done && (!full || pop);
    assign drop      = tok_done && full && !pop;
    assign tok_len   = tok_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= len;
        end
    end

    // Dropped tokens still count.
    always_ff @(posedge clk) begin
        if (reset) begin
            tok_cnt <= '0;
            ovf     <= 1'b0;
        end else begin
            if (tok_done && (tok_cnt != CNT_MAX)) begin
                tok_cnt <= tok_cnt + 1'b1;
            end
            if (drop) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule
